// File: rtl/seg_pkg.sv
// Shared constants and types for the DAC segment recombiner.
// Latency: n/a (package only).
// Backpressure: n/a.
package seg_pkg;

    // Offsets the segmentation stage adds to each code
    localparam int B_OFFSET_DEF = 9;
    localparam int C_OFFSET_DEF = 3;

    // Legal segment code bounds
    localparam int B_MIN = 1;
    localparam int B_MAX = 16;
    localparam int C_MIN = 1;
    localparam int C_MAX = 4;

    // Code and sample widths
    localparam int B_W  = 6;
    localparam int C_W  = 4;
    localparam int Y_W  = 6;
    localparam int BW_W = Y_W - 1;   // offset-removed MSB weight, -8..7
    localparam int C1_W = 3;         // offset-removed LSB weight, -2..1

    // Illegal-code counter
    localparam int ERR_W       = 8;
    localparam int ERR_CNT_MAX = 255;

    // Registered output of the decode stage
    typedef struct packed {
        logic            valid;
        logic            illegal;
        logic [BW_W-1:0] bw;   // two's complement
        logic [C1_W-1:0] c1;   // two's complement
    } dec_t;

endpackage

// File: rtl/seg_code_decode.sv
// Stage 1: clamps B/C to their legal ranges, removes offsets, flags illegal samples.
// Latency: 1 cycle, in_valid -> dec.valid.
// Backpressure: none; accepts one sample per cycle.
// Ports: clock/rst, in_valid + b_code/c_code in, dec (valid, illegal, bw, c1) out.
module seg_code_decode
    import seg_pkg::*;
#(
    parameter int B_OFFSET = B_OFFSET_DEF,
    parameter int C_OFFSET = C_OFFSET_DEF
) (
    input  logic           clock,
    input  logic           rst,
    input  logic           in_valid,
    input  logic [B_W-1:0] b_code,
    input  logic [C_W-1:0] c_code,
    output dec_t           dec
);

    logic [B_W-1:0] b_cl;
    logic [C_W-1:0] c_cl;
    logic           b_bad;
    logic           c_bad;

    always_comb begin
        b_cl  = b_code;
        b_bad = 1'b0;
        if (b_code < B_W'(B_MIN)) begin
            b_cl  = B_W'(B_MIN);
            b_bad = 1'b1;
        end else if (b_code > B_W'(B_MAX)) begin
            b_cl  = B_W'(B_MAX);
            b_bad = 1'b1;
        end
    end

    always_comb begin
        c_cl  = c_code;
        c_bad = 1'b0;
        if (c_code < C_W'(C_MIN)) begin
            c_cl  = C_W'(C_MIN);
            c_bad = 1'b1;
        end else if (c_code > C_W'(C_MAX)) begin
            c_cl  = C_W'(C_MAX);
            c_bad = 1'b1;
        end
    end

    // Data fields only load on a valid sample; valid itself follows in_valid
    // so a bubble drains through the pipeline.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            dec <= '0;
        end else begin
            dec.valid <= in_valid;
            if (in_valid) begin
                // one illegal event per sample even when both codes are bad
                dec.illegal <= b_bad | c_bad;
                dec.bw      <= BW_W'(b_cl - B_W'(B_OFFSET));
                dec.c1      <= C1_W'(c_cl - C_W'(C_OFFSET));
            end
        end
    end

endmodule

// File: rtl/segment_recombiner.sv
// Rebuilds the signed DAC sample from MSB/LSB segment codes, sums it over a
// 2^LOG2_WIN window and tracks illegal codes. Latency: y 2 cycles after
// in_valid, sum_valid 1 cycle after the window's last y_valid. No backpressure.
// Ports: clock/rst, in_valid/B/C/clear in; y_out/y_valid, sum_out/sum_valid,
// range_err (sticky) and err_count (saturating) out.
module segment_recombiner
    import seg_pkg::*;
#(
    parameter int LOG2_WIN = 4,
    parameter int B_OFFSET = B_OFFSET_DEF,
    parameter int C_OFFSET = C_OFFSET_DEF
) (
    input  logic                           clock,
    input  logic                           rst,
    input  logic                           in_valid,
    input  logic [B_W-1:0]                 B,
    input  logic [C_W-1:0]                 C,
    input  logic                           clear,
    output logic signed [Y_W-1:0]          y_out,
    output logic                           y_valid,
    output logic signed [Y_W+LOG2_WIN-1:0] sum_out,
    output logic                           sum_valid,
    output logic                           range_err,
    output logic [ERR_W-1:0]               err_count
);

    localparam int SUM_W = Y_W + LOG2_WIN;

    dec_t                 dec;
    logic [Y_W-1:0]       y_next;
    logic [SUM_W-1:0]     y_ext;
    logic [SUM_W-1:0]     acc;
    logic [LOG2_WIN-1:0]  win_cnt;

    seg_code_decode #(
        .B_OFFSET (B_OFFSET),
        .C_OFFSET (C_OFFSET)
    ) u_decode (
        .clock    (clock),
        .rst      (rst),
        .in_valid (in_valid),
        .b_code   (B),
        .c_code   (C),
        .dec      (dec)
    );

    // y = 2*bw - c1. {bw,0} is exactly 2*bw at Y_W bits, and the result
    // range -17..16 fits Y_W signed, so modular arithmetic is exact.
    assign y_next = {dec.bw, 1'b0} - {{(Y_W-C1_W){dec.c1[C1_W-1]}}, dec.c1};

    assign y_ext = {{LOG2_WIN{y_out[Y_W-1]}}, y_out};

    // Stage 2: recombine. y_out holds between strobes.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            y_out   <= '0;
            y_valid <= 1'b0;
        end else begin
            y_valid <= dec.valid;
            if (dec.valid) begin
                y_out <= y_next;
            end
        end
    end

    // Window accumulator fed from the registered sample. A sample landing on
    // the same cycle as clear is dropped so the new window starts empty.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            acc       <= '0;
            win_cnt   <= '0;
            sum_out   <= '0;
            sum_valid <= 1'b0;
        end else begin
            sum_valid <= 1'b0;
            if (clear) begin
                acc     <= '0;
                win_cnt <= '0;
            end else if (y_valid) begin
                if (win_cnt == {LOG2_WIN{1'b1}}) begin
                    sum_out   <= acc + y_ext;
                    sum_valid <= 1'b1;
                    acc       <= '0;
                    win_cnt   <= '0;
                end else begin
                    acc     <= acc + y_ext;
                    win_cnt <= win_cnt + LOG2_WIN'(1);
                end
            end
        end
    end

    // Error tracking off the decode-stage flag. An illegal sample sitting in
    // the decode register while clear is high still counts, after the clear.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            range_err <= 1'b0;
            err_count <= '0;
        end else begin
            if (dec.valid && dec.illegal) begin
                range_err <= 1'b1;
                if (clear) begin
                    err_count <= ERR_W'(1);
                end else if (err_count != ERR_W'(ERR_CNT_MAX)) begin
                    err_count <= err_count + ERR_W'(1);
                end
            end else if (clear) begin
                range_err <= 1'b0;
                err_count <= '0;
            end
        end
    end

endmodule

// File: tb/tb_segment_recombiner.sv
// Randomized and directed bench for segment_recombiner against a
// cycle-level reference model built from the arithmetic rules.
module tb_segment_recombiner;

    localparam int WIN   = 16;
    localparam int B_OFF = 9;
    localparam int C_OFF = 3;

    logic              clock = 1'b0;
    logic              rst;
    logic              in_valid;
    logic [5:0]        B;
    logic [3:0]        C;
    logic              clear;
    logic signed [5:0] y_out;
    logic              y_valid;
    logic signed [9:0] sum_out;
    logic              sum_valid;
    logic              range_err;
    logic [7:0]        err_count;

    segment_recombiner dut (
        .clock     (clock),
        .rst       (rst),
        .in_valid  (in_valid),
        .B         (B),
        .C         (C),
        .clear     (clear),
        .y_out     (y_out),
        .y_valid   (y_valid),
        .sum_out   (sum_out),
        .sum_valid (sum_valid),
        .range_err (range_err),
        .err_count (err_count)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;
    int sum_pulses = 0;

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        bit v;
        bit ill;
        int y;
    } smp_t;

    smp_t h1, h2;   // samples accepted one and two edges ago
    int m_y, m_yv, m_sum, m_sv, m_acc, m_wc, m_err, m_cnt;

    function automatic smp_t mk(input bit v, input int b, input int c);
        smp_t s;
        int bc, cc;
        bc = (b < 1) ? 1 : ((b > 16) ? 16 : b);
        cc = (c < 1) ? 1 : ((c > 4) ? 4 : c);
        s.v   = v;
        s.ill = v && ((bc != b) || (cc != c));
        s.y   = 2 * (bc - B_OFF) - (cc - C_OFF);
        return s;
    endfunction

    task automatic model_reset();
        h1 = '{0, 0, 0};
        h2 = '{0, 0, 0};
        m_y = 0; m_yv = 0; m_sum = 0; m_sv = 0;
        m_acc = 0; m_wc = 0; m_err = 0; m_cnt = 0;
    endtask

    task automatic compare_all();
        check("y_valid",   y_valid,           m_yv);
        check("y_out",     $signed(y_out),    m_y);
        check("sum_valid", sum_valid,         m_sv);
        check("sum_out",   $signed(sum_out),  m_sum);
        check("range_err", range_err,         m_err);
        check("err_count", err_count,         m_cnt);
    endtask

    // One clock: drive inputs, advance model at the edge, compare just after.
    task automatic step(input bit v, input int b, input int c, input bit clr);
        smp_t cur;
        cur = mk(v, b, c);
        in_valid = v;
        B        = 6'(b);
        C        = 4'(c);
        clear    = clr;
        @(posedge clock);
        // error state: sample in the decode stage, clear applied first
        if (clr) begin
            m_err = 0;
            m_cnt = 0;
        end
        if (h1.v && h1.ill) begin
            m_err = 1;
            if (m_cnt < 255) m_cnt++;
        end
        // window: sample currently on y_out
        m_sv = 0;
        if (clr) begin
            m_acc = 0;
            m_wc  = 0;
        end else if (h2.v) begin
            m_acc += h2.y;
            m_wc++;
            if (m_wc == WIN) begin
                m_sum = m_acc;
                m_sv  = 1;
                m_acc = 0;
                m_wc  = 0;
            end
        end
        m_yv = h1.v;
        if (h1.v) m_y = h1.y;
        h2 = h1;
        h1 = cur;
        #1;
        compare_all();
        if (sum_valid) sum_pulses++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0);
    endtask

    // Reset asserted mid-cycle: outputs must drop without waiting for an edge.
    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        clear    = 1'b0;
        model_reset();
        #1;
        compare_all();
        @(posedge clock);
        #1;
        rst = 1'b0;
    endtask

    task automatic direct(input int b, input int c, input int exp_y);
        step(1, b, c, 0);
        step(0, 0, 0, 0);
        check("direct_y_valid", y_valid, 1);
        check("direct_y", $signed(y_out), exp_y);
    endtask

    int p0;

    initial begin
        rst = 1'b1; in_valid = 1'b0; B = '0; C = '0; clear = 1'b0;
        model_reset();
        #2;
        compare_all();
        repeat (2) @(posedge clock);
        #1;
        rst = 1'b0;

        // midscale codes: y = 0, one window sum of 0
        p0 = sum_pulses;
        for (int i = 0; i < WIN; i++) step(1, 9, 3, 0);
        idle(4);
        check("mid_pulses", sum_pulses - p0, 1);
        check("mid_sum", $signed(sum_out), 0);

        // all legal pairs back to back
        for (int b = 1; b <= 16; b++)
            for (int c = 1; c <= 4; c++) step(1, b, c, 0);
        idle(4);
        direct(16, 1, 16);
        direct(1, 4, -17);
        direct(12, 2, 7);

        // window of y=2 samples with idle gaps
        do_reset();
        p0 = sum_pulses;
        for (int i = 0; i < WIN; i++) begin
            step(1, 10, 3, 0);
            idle($urandom_range(1, 3));
        end
        idle(3);
        check("gap_pulses", sum_pulses - p0, 1);
        check("gap_sum", $signed(sum_out), 32);

        // illegal codes decode from clamped values
        do_reset();
        direct(0, 2, -15);
        direct(9, 7, -1);
        idle(2);
        check("ill_err", range_err, 1);
        check("ill_cnt", err_count, 2);

        // saturation
        for (int i = 0; i < 300; i++) step(1, $urandom_range(17, 63), 3, 0);
        idle(3);
        check("sat_cnt", err_count, 255);

        // clear mid-window after 8 samples restarts the window
        do_reset();
        for (int i = 0; i < 8; i++) step(1, 10, 3, 0);
        idle(2);
        step(0, 0, 0, 1);
        p0 = sum_pulses;
        for (int i = 0; i < WIN - 1; i++) step(1, 10, 3, 0);
        idle(3);
        check("clr_no_early", sum_pulses - p0, 0);
        step(1, 10, 3, 0);
        idle(3);
        check("clr_pulse", sum_pulses - p0, 1);
        check("clr_sum", $signed(sum_out), 32);

        // clear while an illegal sample sits in decode: the new event survives
        for (int i = 0; i < 3; i++) step(1, 0, 3, 0);
        idle(3);
        step(1, 20, 3, 0);
        step(0, 0, 0, 1);
        idle(2);
        check("clr_ill_err", range_err, 1);
        check("clr_ill_cnt", err_count, 1);

        // reset mid-window with samples in flight
        for (int i = 0; i < 5; i++) step(1, 12, 2, 0);
        step(1, 12, 2, 0);
        do_reset();
        idle(2);
        p0 = sum_pulses;
        for (int i = 0; i < WIN - 1; i++) step(1, 12, 2, 0);
        idle(3);
        check("rst_no_early", sum_pulses - p0, 0);
        step(1, 12, 2, 0);
        idle(3);
        check("rst_sum", $signed(sum_out), 112);

        // random traffic
        for (int i = 0; i < 1500; i++) begin
            int b, c;
            b = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 63) : $urandom_range(1, 16);
            c = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 15) : $urandom_range(1, 4);
            step($urandom_range(0, 9) < 7, b, c, $urandom_range(0, 63) == 0);
        end
        idle(4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
